// File: rtl/enduro_fifo_pkg.sv
// rtl/enduro_fifo_pkg.sv - shared Gray-code helpers and output-stage state type for the enduro FIFO
package enduro_fifo_pkg;

  // Widest pointer the helpers handle; callers pass their real width.
  localparam int GRAY_MAX_W = 32;

  // Output register state: EMPTY holds nothing, FULL presents a word.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostage_state_t;

  // Binary to Gray over the low w bits; bits at and above w are zeroed.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b,
                                                     input int w);
    logic [GRAY_MAX_W-1:0] mask;
    mask = (w >= GRAY_MAX_W) ? '1 : ((32'd1 << w) - 32'd1);
    return (b ^ (b >> 1)) & mask;
  endfunction

  // Gray to binary over the low w bits: each binary bit is the XOR of all
  // Gray bits at or above it within the pointer width.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                     input int w);
    logic [GRAY_MAX_W-1:0] b;
    logic                  acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
      if (i < w) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/enduro_gray2bin.sv
// rtl/enduro_gray2bin.sv - combinational Gray-to-binary converter for a synchronized pointer
module enduro_gray2bin
  import enduro_fifo_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  generate
    if (WIDTH < 1 || WIDTH > GRAY_MAX_W) begin : g_bad_width
      $error("enduro_gray2bin: WIDTH must be 1..32");
    end
  endgenerate

  logic [GRAY_MAX_W-1:0] w_gray_ext;
  logic [GRAY_MAX_W-1:0] w_bin_ext;

  assign w_gray_ext = GRAY_MAX_W'(i_gray);
  assign w_bin_ext  = gray2bin(w_gray_ext, WIDTH);
  assign o_bin      = w_bin_ext[WIDTH-1:0];

endmodule

// File: rtl/enduro_fifo_rd_ctrl.sv
// rtl/enduro_fifo_rd_ctrl.sv - read-domain controller: read pointer, first-word-fall-through output stage, Gray pointer return
module enduro_fifo_rd_ctrl
  import enduro_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int MEM_DEPTH  = 64
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   ram_level,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  ptr_err
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH_LIMIT = PTR_W'(MEM_DEPTH);

  generate
    if (MEM_DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("enduro_fifo_rd_ctrl: MEM_DEPTH must equal 2**ADDR_WIDTH");
    end
    if (PTR_W > GRAY_MAX_W) begin : g_bad_addr
      $error("enduro_fifo_rd_ctrl: ADDR_WIDTH too large for Gray helpers");
    end
  endgenerate

  logic [PTR_W-1:0]      w_wr_bin;
  logic [PTR_W-1:0]      w_rd_bin_nxt;
  logic [PTR_W-1:0]      w_ram_level;
  logic [GRAY_MAX_W-1:0] w_rd_gray_nxt_ext;
  logic                  w_ram_empty;
  logic                  w_accept;
  logic                  w_fetch;

  logic [PTR_W-1:0]      r_rd_bin;
  logic [PTR_W-1:0]      r_rd_ptr_gray;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;
  logic                  r_ptr_err;
  ostage_state_t         r_state;

  enduro_gray2bin #(
    .WIDTH (PTR_W)
  ) u_wr_gray2bin (
    .i_gray (wr_ptr_gray_sync),
    .o_bin  (w_wr_bin)
  );

  // RAM holds unfetched words whenever the pointers differ; the output stage
  // can take a new word when it is idle or its word is leaving this cycle.
  assign w_ram_empty       = (w_wr_bin == r_rd_bin);
  assign w_accept          = r_m_valid && m_ready;
  assign w_fetch           = !w_ram_empty && (!r_m_valid || m_ready);
  assign w_rd_bin_nxt      = r_rd_bin + PTR_W'(1);
  assign w_rd_gray_nxt_ext = bin2gray(GRAY_MAX_W'(w_rd_bin_nxt), PTR_W);
  assign w_ram_level       = w_wr_bin - r_rd_bin;

  // Output-stage FSM: advances the read pointer and loads the output word on fetch.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_state       <= EMPTY;
      r_m_valid     <= 1'b0;
      r_m_data      <= '0;
      r_rd_bin      <= '0;
      r_rd_ptr_gray <= '0;
    end else begin
      if (w_fetch) begin
        r_m_data      <= ram_rd_data;
        r_rd_bin      <= w_rd_bin_nxt;
        r_rd_ptr_gray <= w_rd_gray_nxt_ext[PTR_W-1:0];
      end
      case (r_state)
        EMPTY: begin
          if (w_fetch) begin
            r_state   <= FULL;
            r_m_valid <= 1'b1;
          end
        end
        FULL: begin
          if (w_accept && !w_fetch) begin
            r_state   <= EMPTY;
            r_m_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= EMPTY;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag: more words claimed in RAM than it can hold means the pointers disagree.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_ptr_err <= 1'b0;
    end else if (w_ram_level > DEPTH_LIMIT) begin
      r_ptr_err <= 1'b1;
    end
  end

  assign ram_rd_addr = r_rd_bin[ADDR_WIDTH-1:0];
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign empty       = !r_m_valid;
  assign ram_level   = w_ram_level;
  assign rd_ptr_gray = r_rd_ptr_gray;
  assign ptr_err     = r_ptr_err;

endmodule

// File: tb/tb_enduro_fifo_rd_ctrl.sv
// tb/tb_enduro_fifo_rd_ctrl.sv - self-checking bench for enduro_fifo_rd_ctrl
module tb_enduro_fifo_rd_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 64;

  logic          rd_clk;
  logic          rd_rst_n;
  logic [PW-1:0] wr_ptr_gray_sync;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          empty;
  logic [PW-1:0] ram_level;
  logic [PW-1:0] rd_ptr_gray;
  logic          ptr_err;

  logic [DW-1:0] mem [DEPTH];
  assign ram_rd_data = mem[ram_rd_addr];

  int n_checks;
  int n_pass;

  // Model: total words written, total words accepted by the consumer, and
  // the written-but-not-yet-accepted words in order.
  int            wr_cnt;
  int            acc_cnt;
  logic [DW-1:0] q[$];

  enduro_fifo_rd_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .rd_clk           (rd_clk),
    .rd_rst_n         (rd_rst_n),
    .wr_ptr_gray_sync (wr_ptr_gray_sync),
    .ram_rd_addr      (ram_rd_addr),
    .ram_rd_data      (ram_rd_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .empty            (empty),
    .ram_level        (ram_level),
    .rd_ptr_gray      (rd_ptr_gray),
    .ptr_err          (ptr_err)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] gray_of(input int v);
    logic [PW-1:0] b;
    b = v[PW-1:0];
    return b ^ (b >> 1);
  endfunction

  // A word is presented whenever some written word has not been accepted yet.
  function automatic int exp_valid();
    return ((wr_cnt - acc_cnt) > 0) ? 1 : 0;
  endfunction

  function automatic int fetched();
    return acc_cnt + exp_valid();
  endfunction

  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_cnt % DEPTH] = d;
    q.push_back(d);
    wr_cnt++;
    wr_ptr_gray_sync = gray_of(wr_cnt);
  endtask

  task automatic run_cycle(input logic rdy);
    logic acc;
    m_ready = rdy;
    acc = m_valid && rdy;
    @(posedge rd_clk);
    if (acc) begin
      acc_cnt++;
      q.delete(0);
    end
    @(negedge rd_clk);
  endtask

  task automatic do_reset();
    rd_rst_n = 1'b0;
    m_ready = 1'b0;
    wr_cnt = 0;
    acc_cnt = 0;
    q.delete();
    wr_ptr_gray_sync = '0;
    @(negedge rd_clk);
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    @(negedge rd_clk);
  endtask

  task automatic test_reset();
    logic [DW+2*PW+AW+2:0] got;
    logic [DW+2*PW+AW+2:0] want;
    do_reset();
    got  = {m_valid, empty, ptr_err, rd_ptr_gray, ram_rd_addr, ram_level, m_data};
    want = {1'b0, 1'b1, 1'b0, 7'd0, 6'd0, 7'd0, 32'd0};
    n_checks++;
    if (got !== want) $display("FAIL reset_outputs: got %h expected %h", got, want);
    else n_pass++;
    rd_rst_n = 1'b0;
    wr_ptr_gray_sync = gray_of(5);
    #1;
    n_checks++;
    if (ram_level !== 7'd5) $display("FAIL reset_level_follows_wr: got %0d expected 5", ram_level);
    else n_pass++;
    n_checks++;
    if (m_valid !== 1'b0 || rd_ptr_gray !== 7'd0) $display("FAIL reset_hold: m_valid %b gray %h expected 0 0", m_valid, rd_ptr_gray);
    else n_pass++;
    wr_ptr_gray_sync = '0;
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    do_reset();
    push_word(32'hA5A5_0001);
    run_cycle(1'b0);
    n_checks++;
    if (m_valid !== 1'b1 || empty !== 1'b0) $display("FAIL single_valid: m_valid %b empty %b expected 1 0", m_valid, empty);
    else n_pass++;
    n_checks++;
    if (m_data !== 32'hA5A5_0001) $display("FAIL single_data: got %h expected a5a50001", m_data);
    else n_pass++;
    n_checks++;
    if (rd_ptr_gray !== 7'h01 || ram_level !== 7'd0) $display("FAIL single_ptr: gray %h level %0d expected 01 0", rd_ptr_gray, ram_level);
    else n_pass++;
    run_cycle(1'b1);
    n_checks++;
    if (m_valid !== 1'b0 || empty !== 1'b1) $display("FAIL single_drain: m_valid %b empty %b expected 0 1", m_valid, empty);
    else n_pass++;
    n_checks++;
    if (m_data !== 32'hA5A5_0001) $display("FAIL single_data_hold: got %h expected a5a50001", m_data);
    else n_pass++;
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'h10 + i);
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b1);
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== DW'(32'h10 + i))
        $display("FAIL stream_word%0d: valid %b data %h expected 1 %h", i, m_valid, m_data, 32'h10 + i);
      else n_pass++;
    end
    n_checks++;
    if (rd_ptr_gray !== 7'h06) $display("FAIL stream_gray: got %h expected 06", rd_ptr_gray);
    else n_pass++;
    run_cycle(1'b1);
    n_checks++;
    if (m_valid !== 1'b0) $display("FAIL stream_end: m_valid %b expected 0", m_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] first;
    do_reset();
    for (int i = 0; i < 3; i++) push_word($urandom);
    first = q[0];
    for (int c = 0; c < 5; c++) begin
      run_cycle(1'b0);
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== first || ram_rd_addr !== 6'd1 || ram_level !== 7'd2)
        $display("FAIL bp_stall%0d: valid %b data %h addr %0d level %0d expected 1 %h 1 2",
                 c, m_valid, m_data, ram_rd_addr, ram_level, first);
      else n_pass++;
    end
    for (int c = 0; c < 6; c++) begin
      run_cycle(1'b1);
      if (m_valid) begin
        n_checks++;
        if (m_data !== q[0]) $display("FAIL bp_order: got %h expected %h", m_data, q[0]);
        else n_pass++;
      end
    end
    n_checks++;
    if (acc_cnt !== 3 || m_valid !== 1'b0 || rd_ptr_gray !== gray_of(3))
      $display("FAIL bp_count: accepted %0d valid %b gray %h expected 3 0 %h", acc_cnt, m_valid, rd_ptr_gray, gray_of(3));
    else n_pass++;
  endtask

  task automatic test_wrap();
    int  exp_addr [4];
    int  n;
    exp_addr = '{62, 63, 0, 1};
    do_reset();
    for (int i = 0; i < 62; i++) begin
      push_word(DW'(i));
      run_cycle(1'b1);
    end
    n = 0;
    while (m_valid && n < 8) begin
      run_cycle(1'b1);
      n++;
    end
    n_checks++;
    if (ram_rd_addr !== 6'd62 || m_valid !== 1'b0) $display("FAIL wrap_start: addr %0d valid %b expected 62 0", ram_rd_addr, m_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) push_word(32'hC0DE_0000 + i);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ram_rd_addr !== AW'(exp_addr[k])) $display("FAIL wrap_addr%0d: got %0d expected %0d", k, ram_rd_addr, exp_addr[k]);
      else n_pass++;
      run_cycle(1'b1);
      n_checks++;
      if (m_data !== q[0]) $display("FAIL wrap_data%0d: got %h expected %h", k, m_data, q[0]);
      else n_pass++;
      if (k == 1) begin
        n_checks++;
        if (rd_ptr_gray !== 7'h60) $display("FAIL wrap_gray64: got %h expected 60", rd_ptr_gray);
        else n_pass++;
      end
    end
    for (int i = 0; i < 62; i++) begin
      push_word($urandom);
      run_cycle(1'b1);
      if (m_valid) begin
        n_checks++;
        if (m_data !== q[0]) $display("FAIL wrap_pass2: got %h expected %h", m_data, q[0]);
        else n_pass++;
      end
    end
    n = 0;
    while (m_valid && n < 8) begin
      run_cycle(1'b1);
      n++;
    end
    n_checks++;
    if (rd_ptr_gray !== 7'h00 || ram_rd_addr !== 6'd0 || empty !== 1'b1 || ram_level !== 7'd0)
      $display("FAIL wrap_127_to_0: gray %h addr %0d empty %b level %0d expected 00 0 1 0",
               rd_ptr_gray, ram_rd_addr, empty, ram_level);
    else n_pass++;
  endtask

  task automatic test_error_and_reset();
    do_reset();
    m_ready = 1'b0;
    wr_ptr_gray_sync = gray_of(64);
    @(posedge rd_clk);
    @(negedge rd_clk);
    n_checks++;
    if (ptr_err !== 1'b0 || ram_level !== 7'd63) $display("FAIL err_boundary64: ptr_err %b level %0d expected 0 63", ptr_err, ram_level);
    else n_pass++;
    wr_ptr_gray_sync = gray_of(1 + 65);
    @(posedge rd_clk);
    @(negedge rd_clk);
    n_checks++;
    if (ptr_err !== 1'b1) $display("FAIL err_set: ptr_err %b expected 1", ptr_err);
    else n_pass++;
    wr_ptr_gray_sync = gray_of(1);
    @(posedge rd_clk);
    @(negedge rd_clk);
    n_checks++;
    if (ptr_err !== 1'b1 || ram_level !== 7'd0 || m_valid !== 1'b1)
      $display("FAIL err_sticky: ptr_err %b level %0d valid %b expected 1 0 1", ptr_err, ram_level, m_valid);
    else n_pass++;
    rd_rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || ptr_err !== 1'b0 || empty !== 1'b1 || m_data !== 32'd0 || rd_ptr_gray !== 7'd0)
      $display("FAIL err_async_reset: valid %b ptr_err %b empty %b data %h gray %h expected 0 0 1 0 0",
               m_valid, ptr_err, empty, m_data, rd_ptr_gray);
    else n_pass++;
    wr_ptr_gray_sync = '0;
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
  endtask

  task automatic test_random();
    int wp;
    int rp;
    int ev;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      case ((cyc / 100) % 4)
        0: begin wp = 80; rp = 30; end
        1: begin wp = 30; rp = 90; end
        2: begin wp = 95; rp = 95; end
        default: begin wp = 50; rp = 50; end
      endcase
      if ((wr_cnt - acc_cnt) < DEPTH && $urandom_range(0, 99) < wp) push_word($urandom);
      run_cycle($urandom_range(0, 99) < rp);
      ev = exp_valid();
      n_checks++;
      if (m_valid !== ev[0] || empty !== !ev[0]) $display("FAIL rnd_valid c%0d: valid %b expected %0d", cyc, m_valid, ev);
      else n_pass++;
      if (ev != 0) begin
        n_checks++;
        if (m_data !== q[0]) $display("FAIL rnd_data c%0d: got %h expected %h", cyc, m_data, q[0]);
        else n_pass++;
      end
      n_checks++;
      if (ram_level !== PW'(wr_cnt - fetched()) || rd_ptr_gray !== gray_of(fetched()) ||
          ram_rd_addr !== AW'(fetched() % DEPTH) || ptr_err !== 1'b0)
        $display("FAIL rnd_ptrs c%0d: level %0d gray %h addr %0d err %b expected %0d %h %0d 0", cyc,
                 ram_level, rd_ptr_gray, ram_rd_addr, ptr_err,
                 PW'(wr_cnt - fetched()), gray_of(fetched()), fetched() % DEPTH);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rd_rst_n = 1'b0;
    m_ready = 1'b0;
    wr_ptr_gray_sync = '0;
    wr_cnt = 0;
    acc_cnt = 0;
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_error_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/enduro_fifo_rd_ctrl.md
# enduro_fifo_rd_ctrl

Read-side controller for the enduro asynchronous FIFO. It lives in the read clock domain and owns the read pointer. It drives the address port of the enduro dual-port RAM and fetches words through a single registered output stage with a valid/ready handshake, so the first word falls through to the output. It also returns a Gray-coded read pointer to the write domain for synchronization.

## Interface
- DATA_WIDTH, 32, width of each FIFO word
- ADDR_WIDTH, 6, RAM address bits; pointers are ADDR_WIDTH+1 bits (one wrap bit)
- MEM_DEPTH, 64, RAM depth; must equal 2**ADDR_WIDTH (elaboration error otherwise)

- rd_clk  in  1  read-domain clock; single clock for the block
- rd_rst_n  in  1  asynchronous, active-low reset
- wr_ptr_gray_sync  in  ADDR_WIDTH+1  write pointer, Gray code, already synchronized into rd_clk
- ram_rd_addr  out  ADDR_WIDTH  RAM read address; the RAM returns data combinationally
- ram_rd_data  in  DATA_WIDTH  RAM read data for ram_rd_addr, same cycle
- m_valid  out  1  m_data holds a valid word
- m_ready  in  1  consumer accepts the word when m_valid && m_ready
- m_data  out  DATA_WIDTH  output word
- empty  out  1  equals !m_valid
- ram_level  out  ADDR_WIDTH+1  words in RAM not yet fetched: (wr_bin − rd_bin) mod 2**(ADDR_WIDTH+1)
- rd_ptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write-domain synchronizer
- ptr_err  out  1  sticky flag for a pointer-consistency error

## Operation
- wr_bin is the combinational Gray-to-binary conversion of wr_ptr_gray_sync.
- rd_bin is a register. ram_rd_addr = rd_bin[ADDR_WIDTH-1:0].
- ram_empty = (wr_bin == rd_bin).
- fetch = !ram_empty && (!m_valid || m_ready).
- When fetch is high: m_data <= ram_rd_data, m_valid <= 1, rd_bin <= rd_bin + 1 (modulo 2**(ADDR_WIDTH+1)). rd_ptr_gray <= bin2gray(rd_bin + 1).
- When m_valid && m_ready && ram_empty: m_valid <= 0. m_data keeps its last value.
- When m_valid && !m_ready: m_data, m_valid and rd_bin hold.
- Output-stage states:
  - EMPTY (m_valid=0): goes to FULL on fetch.
  - FULL (m_valid=1): stays FULL on accept with fetch or on stall; goes to EMPTY on accept without fetch.
- ram_level = wr_bin − rd_bin, unsigned, in ADDR_WIDTH+1 bits.
- ptr_err sets when ram_level > MEM_DEPTH and stays set until reset. The block keeps operating; no pointer is clamped.
- Address wrap: addresses run 63 → 0; the wrap bit toggles each pass.

## Timing
- Reset (asynchronous assert, synchronous-release safe): rd_bin=0, rd_ptr_gray=0, m_valid=0, m_data=0, ptr_err=0. Consequently ram_rd_addr=0, empty=1, ram_level=wr_bin.
- Latency: a wr_ptr_gray_sync increment at edge N gives m_valid=1 after edge N+1 if the output stage is EMPTY.
- Throughput: one word per cycle while ram_level>0 and m_ready=1.
- No combinational path from m_ready to m_valid or m_data. m_ready to the rd_bin enable is combinational (one gate level).
- rd_ptr_gray is a flop output and changes by exactly one bit per increment.
- Reset asserted mid-stream: outputs go to reset values immediately. The buffered word is discarded.

## Structure
- Shared package enduro_fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterized by width
  - a typedef for the output-stage state enum {EMPTY, FULL}
- One sub-module, enduro_gray2bin: combinational, WIDTH parameter, instantiated once for wr_ptr_gray_sync.

## Test plan
- Reset: with wr_ptr_gray_sync=0, pulse rd_rst_n low → all outputs 0, empty=1, ptr_err=0.
- Single word: RAM[0]=0xA5A5_0001, wr_ptr_gray_sync 0→1 → next cycle m_valid=1, m_data=0xA5A5_0001, rd_ptr_gray=1, ram_level=0. Then m_ready=1 for one cycle → m_valid=0.
- Streaming: RAM[0..3]=0x10..0x13, wr_bin=4, m_ready=1 → m_data 0x10,0x11,0x12,0x13 on consecutive cycles; rd_ptr_gray ends at 0x6 (bin 4).
- Backpressure: wr_bin=3, m_ready=0 for 5 cycles → m_data=RAM[0] stable, rd_bin=1, ram_level=2. Release m_ready → remaining words in order with no loss or duplicates.
- Wrap: preload rd_bin=62, wr_bin=66 → addresses 62,63,0,1. rd_ptr_gray at bin 64 = 0x60; a later pass wraps 127→0 with rd_ptr_gray=0x00.
- Error and reset mid-stream: force wr_bin=rd_bin+65 → ptr_err=1 and stays 1 after pointers realign. Assert rd_rst_n low while m_valid=1 → m_valid=0 and ptr_err=0 immediately.
